insn_fetch_ctrl: RTL and testbench

Fetch sequencer between the instruction memory port and the core's decode stage. It issues one instruction-memory request at a time and holds the returned word for the core under a valid/ready handshake. Before issuing, it screens the opcode against the supported RV32I base set. It also handles control-flow redirects and traps on illegal opcodes.

---
 rtl/insn_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_insn_fetch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem request, opcode screening, redirects and illegal-opcode trap.
// Optional macro RETIRE_CNT_EN builds the retire counter; otherwise o_retire_cnt is tied to 0.
module insn_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   output logic             o_imem_req,
   output logic [31:0]      o_imem_addr,
   input  logic             i_imem_ack,
   input  logic [31:0]      i_imem_rdata,
   output logic [31:0]      o_inst,
   output logic [31:0]      o_inst_pc,
   output logic             o_inst_vld,
   input  logic             i_inst_rdy,
   input  logic             i_redirect,
   input  logic [31:0]      i_redirect_pc,
   output logic             o_illegal,
   output logic [31:0]      o_illegal_pc,
   input  logic             i_illegal_clr,
   output logic [CNT_W-1:0] o_retire_cnt
);

   typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, TRAP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] illegal_pc_q, illegal_pc_d;
   logic [31:0] redirect_tgt;
   logic        opcode_ok;
   logic        handshake;

   assign redirect_tgt = i_redirect_pc & ~32'h3;
   assign handshake    = (state_q == HOLD) && i_inst_rdy;

   always_comb begin
      case (i_imem_rdata[6:0])
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: opcode_ok = 1'b1;
         default:                                        opcode_ok = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         illegal_pc_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         illegal_pc_q <= illegal_pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = REQ;
         REQ: begin
            if (i_redirect)      state_d = i_imem_ack ? REQ : DRAIN;
            else if (i_imem_ack) state_d = opcode_ok ? HOLD : TRAP;
         end
         HOLD:  if (i_redirect || handshake) state_d = REQ;
         DRAIN: if (i_imem_ack) state_d = REQ;
         TRAP:  if (i_redirect || i_illegal_clr) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   // A redirect always wins over the sequential pc update in every state.
   always_comb begin
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      illegal_pc_d = illegal_pc_q;
      case (state_q)
         REQ: begin
            if (i_redirect) begin
               pc_d         = redirect_tgt;
               drain_addr_d = pc_q;
            end else if (i_imem_ack) begin
               if (opcode_ok) begin
                  inst_d    = i_imem_rdata;
                  inst_pc_d = pc_q;
               end else begin
                  illegal_pc_d = pc_q;
               end
            end
         end
         HOLD: begin
            if (i_redirect)     pc_d = redirect_tgt;
            else if (handshake) pc_d = pc_q + 32'd4;
         end
         TRAP: begin
            if (i_redirect)         pc_d = redirect_tgt;
            else if (i_illegal_clr) pc_d = illegal_pc_q + 32'd4;
         end
         default: begin
            if (i_redirect) pc_d = redirect_tgt;
         end
      endcase
   end

   always_comb begin
      o_imem_req  = (state_q == REQ) || (state_q == DRAIN);
      o_imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
      o_inst_vld  = (state_q == HOLD);
      o_illegal   = (state_q == TRAP);
   end

   assign o_inst       = inst_q;
   assign o_inst_pc    = inst_pc_q;
   assign o_illegal_pc = illegal_pc_q;

`ifdef RETIRE_CNT_EN
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (handshake) retire_cnt_d = retire_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) retire_cnt_q <= '0;
      else          retire_cnt_q <= retire_cnt_d;
   end

   assign o_retire_cnt = retire_cnt_q;
`else
   assign o_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Directed-vector bench for insn_fetch_ctrl; expected retire counts follow the RETIRE_CNT_EN build.
module tb_insn_fetch_ctrl;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        o_inst_vld;
   logic        i_inst_rdy;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_illegal;
   logic [31:0] o_illegal_pc;
   logic        i_illegal_clr;
   logic [31:0] o_retire_cnt;

   int n_vec = 0;
   int n_err = 0;

   insn_fetch_ctrl dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (i_imem_ack),
      .i_imem_rdata  (i_imem_rdata),
      .o_inst        (o_inst),
      .o_inst_pc     (o_inst_pc),
      .o_inst_vld    (o_inst_vld),
      .i_inst_rdy    (i_inst_rdy),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_illegal     (o_illegal),
      .o_illegal_pc  (o_illegal_pc),
      .i_illegal_clr (i_illegal_clr),
      .o_retire_cnt  (o_retire_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [31:0] cnt_exp(input int n);
`ifdef RETIRE_CNT_EN
      return 32'(n);
`else
      return 32'd0 + 32'(n - n);
`endif
   endfunction

   initial begin
      i_reset = 1'b0; i_imem_ack = 1'b0; i_imem_rdata = '0; i_inst_rdy = 1'b0;
      i_redirect = 1'b0; i_redirect_pc = '0; i_illegal_clr = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_req",     {31'd0, o_imem_req}, 32'd0);
      check("rst_addr",    o_imem_addr, 32'h0);
      check("rst_vld",     {31'd0, o_inst_vld}, 32'd0);
      check("rst_inst",    o_inst, 32'h0);
      check("rst_illegal", {31'd0, o_illegal}, 32'd0);
      check("rst_cnt",     o_retire_cnt, 32'd0);
      #3 i_reset = 1'b1;

      // Back-to-back zero-wait fetches at 0x0 and 0x4
      step();
      check("s1_req0",  {31'd0, o_imem_req}, 32'd1);
      check("s1_addr0", o_imem_addr, 32'h0);
      i_imem_ack = 1'b1; i_imem_rdata = 32'h0000_0013; i_inst_rdy = 1'b1;
      step();
      i_imem_ack = 1'b0;
      check("s1_vld0",  {31'd0, o_inst_vld}, 32'd1);
      check("s1_req_lo",{31'd0, o_imem_req}, 32'd0);
      check("s1_inst0", o_inst, 32'h0000_0013);
      check("s1_ipc0",  o_inst_pc, 32'h0);
      step();
      check("s1_addr1", o_imem_addr, 32'h4);
      check("s1_cnt1",  o_retire_cnt, cnt_exp(1));
      i_imem_ack = 1'b1; i_imem_rdata = 32'h0010_0093;
      step();
      i_imem_ack = 1'b0;
      check("s1_inst1", o_inst, 32'h0010_0093);
      check("s1_ipc1",  o_inst_pc, 32'h4);
      step();
      check("s1_cnt2",  o_retire_cnt, cnt_exp(2));
      check("s2_addr8", o_imem_addr, 32'h8);

      // Illegal opcode at 0x8, then clear
      i_imem_ack = 1'b1; i_imem_rdata = 32'hFFFF_FFFF;
      step();
      i_imem_ack = 1'b0;
      check("s2_illegal", {31'd0, o_illegal}, 32'd1);
      check("s2_ill_pc",  o_illegal_pc, 32'h8);
      for (int i = 0; i < 2; i++) begin
         check("s2_noreq", {31'd0, o_imem_req}, 32'd0);
         check("s2_novld", {31'd0, o_inst_vld}, 32'd0);
         step();
      end
      check("s2_cnt", o_retire_cnt, cnt_exp(2));
      i_illegal_clr = 1'b1;
      step();
      i_illegal_clr = 1'b0;
      check("s2_clr_req",  {31'd0, o_imem_req}, 32'd1);
      check("s2_clr_addr", o_imem_addr, 32'hC);
      check("s2_clr_ill",  {31'd0, o_illegal}, 32'd0);

      // Redirect to 0x103 in the first request cycle; ack arrives 3 cycles later
      i_redirect = 1'b1; i_redirect_pc = 32'h0000_0103;
      step();
      i_redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("s3_hold_addr", o_imem_addr, 32'hC);
         check("s3_hold_req",  {31'd0, o_imem_req}, 32'd1);
         step();
      end
      check("s3_hold_addr", o_imem_addr, 32'hC);
      i_imem_ack = 1'b1; i_imem_rdata = 32'h0000_0013;
      step();
      i_imem_ack = 1'b0;
      check("s3_dropped", {31'd0, o_inst_vld}, 32'd0);
      check("s3_addr",    o_imem_addr, 32'h100);

      // Redirect coinciding with ack drops the word and refetches at 0x20
      i_redirect = 1'b1; i_redirect_pc = 32'h20; i_imem_ack = 1'b1;
      step();
      i_redirect = 1'b0;
      check("s4_drop_vld", {31'd0, o_inst_vld}, 32'd0);
      check("s4_addr20",   o_imem_addr, 32'h20);
      i_inst_rdy = 1'b0; i_imem_rdata = 32'h0050_0113;
      step();
      i_imem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("s4_stall_vld",  {31'd0, o_inst_vld}, 32'd1);
         check("s4_stall_inst", o_inst, 32'h0050_0113);
         check("s4_stall_ipc",  o_inst_pc, 32'h20);
         check("s4_stall_req",  {31'd0, o_imem_req}, 32'd0);
         step();
      end
      i_redirect = 1'b1; i_redirect_pc = 32'h40; i_inst_rdy = 1'b1;
      step();
      i_redirect = 1'b0;
      check("s4_cnt3",   o_retire_cnt, cnt_exp(3));
      check("s4_addr40", o_imem_addr, 32'h40);

      // pc wrap from 0xFFFFFFFC
      i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC; i_imem_ack = 1'b1;
      step();
      i_redirect = 1'b0;
      check("s5_addr_top", o_imem_addr, 32'hFFFF_FFFC);
      i_imem_rdata = 32'h0000_0037;
      step();
      i_imem_ack = 1'b0;
      check("s5_ipc_top", o_inst_pc, 32'hFFFF_FFFC);
      step();
      check("s5_wrap",  o_imem_addr, 32'h0);
      check("s5_cnt4",  o_retire_cnt, cnt_exp(4));

      // Reset asserted while draining
      i_redirect = 1'b1; i_redirect_pc = 32'h200;
      step();
      i_redirect = 1'b0;
      check("s6_drain_req",  {31'd0, o_imem_req}, 32'd1);
      check("s6_drain_addr", o_imem_addr, 32'h0);
      i_imem_ack = 1'b1;
      #2 i_reset = 1'b0;
      #1;
      check("s6_rst_req",   {31'd0, o_imem_req}, 32'd0);
      check("s6_rst_inst",  o_inst, 32'h0);
      check("s6_rst_ipc",   o_inst_pc, 32'h0);
      check("s6_rst_illpc", o_illegal_pc, 32'h0);
      check("s6_rst_cnt",   o_retire_cnt, 32'd0);
      i_imem_ack = 1'b0;
      step();
      check("s6_rst_hold", {31'd0, o_imem_req}, 32'd0);
      #2 i_reset = 1'b1;
      step();
      check("s6_restart_req",  {31'd0, o_imem_req}, 32'd1);
      check("s6_restart_addr", o_imem_addr, 32'h0);

      // Illegal word 0, then redirect together with clear: redirect wins
      i_imem_ack = 1'b1; i_imem_rdata = 32'h0;
      step();
      i_imem_ack = 1'b0;
      check("s7_illegal", {31'd0, o_illegal}, 32'd1);
      i_redirect = 1'b1; i_redirect_pc = 32'h80; i_illegal_clr = 1'b1;
      step();
      i_redirect = 1'b0; i_illegal_clr = 1'b0;
      check("s7_addr80", o_imem_addr, 32'h80);
      check("s7_req",    {31'd0, o_imem_req}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   always @(negedge i_clk) begin
      if (o_inst_vld && o_imem_req) begin
         n_vec++;
         n_err++;
         $display("FAIL vld_req_overlap: got vld=1 req=1, expected not both");
      end
   end

endmodule
